// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit: Moore FSM sequencing fetch, decode, memory,
// ALU and branch phases, plus a retired-instruction counter.
module multicycle_control #(
   parameter int MEM_HANDSHAKE = 1,
   parameter int ALUOP_W       = 6,
   parameter int CNT_W         = 16
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [5:0]         i_instrCode,
   input  logic               i_memReady,
   output logic               o_pcWrite,
   output logic               o_pcWriteCond,
   output logic               o_pcWriteCondNe,
   output logic               o_iorD,
   output logic               o_memRead,
   output logic               o_memWrite,
   output logic               o_irWrite,
   output logic               o_regDst,
   output logic               o_regWrite,
   output logic               o_memToReg,
   output logic               o_extOp,
   output logic               o_aluSrcA,
   output logic [1:0]         o_aluSrcB,
   output logic [1:0]         o_pcSource,
   output logic [ALUOP_W-1:0] o_aluOp,
   output logic               o_illegal,
   output logic [3:0]         o_state,
   output logic [CNT_W-1:0]   o_retired
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXEC    = 4'd6,
      S_RWB     = 4'd7,
      S_IMMEXEC = 4'd8,
      S_IMMWB   = 4'd9,
      S_BRANCH  = 4'd10,
      S_JUMP    = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_JUMP  = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] ALU_ADD  = 6'h09;

   state_t           r_state;
   state_t           w_next;
   logic [5:0]       r_opcode;
   logic [CNT_W-1:0] r_retired;
   logic             w_memDone;
   logic             w_retire;

   logic             w_pcWrite;
   logic             w_pcWriteCond;
   logic             w_pcWriteCondNe;
   logic             w_iorD;
   logic             w_memRead;
   logic             w_memWrite;
   logic             w_irWrite;
   logic             w_regDst;
   logic             w_regWrite;
   logic             w_memToReg;
   logic             w_extOp;
   logic             w_aluSrcA;
   logic [1:0]       w_aluSrcB;
   logic [1:0]       w_pcSource;
   logic [5:0]       w_aluOp;
   logic             w_illegal;

   // Without the handshake every memory access is treated as finishing in its first cycle.
   assign w_memDone = (MEM_HANDSHAKE == 0) ? 1'b1 : i_memReady;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= S_FETCH;
         r_opcode  <= '0;
         r_retired <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_DECODE) begin
            r_opcode <= i_instrCode;
         end
         if (w_retire) begin
            r_retired <= r_retired + CNT_W'(1);
         end
      end
   end

   always_comb begin
      w_next   = S_FETCH;
      w_retire = 1'b0;
      case (r_state)
         S_FETCH:   w_next = w_memDone ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (i_instrCode)
               OP_RTYPE:                          w_next = S_EXEC;
               OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI: w_next = S_IMMEXEC;
               OP_LW, OP_SW:                      w_next = S_MEMADR;
               OP_BEQ, OP_BNE:                    w_next = S_BRANCH;
               OP_JUMP:                           w_next = S_JUMP;
               default:                           w_next = S_FETCH;
            endcase
         end
         S_MEMADR:  w_next = (r_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:   w_next = w_memDone ? S_MEMWB : S_MEMRD;
         S_MEMWB: begin
            w_next   = S_FETCH;
            w_retire = 1'b1;
         end
         S_MEMWR: begin
            w_next   = w_memDone ? S_FETCH : S_MEMWR;
            w_retire = w_memDone;
         end
         S_EXEC:    w_next = S_RWB;
         S_IMMEXEC: w_next = S_IMMWB;
         S_RWB, S_IMMWB, S_BRANCH, S_JUMP: begin
            w_next   = S_FETCH;
            w_retire = 1'b1;
         end
         default:   w_next = S_FETCH;
      endcase
   end

   always_comb begin
      w_pcWrite       = 1'b0;
      w_pcWriteCond   = 1'b0;
      w_pcWriteCondNe = 1'b0;
      w_iorD          = 1'b0;
      w_memRead       = 1'b0;
      w_memWrite      = 1'b0;
      w_irWrite       = 1'b0;
      w_regDst        = 1'b0;
      w_regWrite      = 1'b0;
      w_memToReg      = 1'b0;
      w_extOp         = 1'b0;
      w_aluSrcA       = 1'b0;
      w_aluSrcB       = 2'b00;
      w_pcSource      = 2'b00;
      w_aluOp         = 6'h00;
      w_illegal       = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_memRead = 1'b1;
            w_aluSrcB = 2'b01;
            w_aluOp   = ALU_ADD;
            w_irWrite = w_memDone;
            w_pcWrite = w_memDone;
         end
         S_DECODE: begin
            w_aluSrcB = 2'b11;
            w_aluOp   = ALU_ADD;
            // The opcode is not latched yet, so the illegal check looks at the live field.
            case (i_instrCode)
               OP_RTYPE, OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI,
               OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_JUMP: w_illegal = 1'b0;
               default:                               w_illegal = 1'b1;
            endcase
         end
         S_MEMADR: begin
            w_aluSrcA = 1'b1;
            w_aluSrcB = 2'b10;
            w_extOp   = 1'b1;
            w_aluOp   = ALU_ADD;
         end
         S_MEMRD: begin
            w_memRead = 1'b1;
            w_iorD    = 1'b1;
         end
         S_MEMWB: begin
            w_regWrite = 1'b1;
            w_memToReg = 1'b1;
         end
         S_MEMWR: begin
            w_memWrite = 1'b1;
            w_iorD     = 1'b1;
         end
         S_EXEC: begin
            w_aluSrcA = 1'b1;
            w_aluOp   = r_opcode;
         end
         S_RWB: begin
            w_regDst   = 1'b1;
            w_regWrite = 1'b1;
         end
         S_IMMEXEC: begin
            w_aluSrcA = 1'b1;
            w_aluSrcB = 2'b10;
            w_aluOp   = r_opcode;
            w_extOp   = (r_opcode == OP_ADDI) || (r_opcode == OP_ADDIU);
         end
         S_IMMWB: begin
            w_regWrite = 1'b1;
         end
         S_BRANCH: begin
            w_aluSrcA       = 1'b1;
            w_aluOp         = r_opcode;
            w_pcSource      = 2'b01;
            w_pcWriteCond   = (r_opcode == OP_BEQ);
            w_pcWriteCondNe = (r_opcode == OP_BNE);
         end
         S_JUMP: begin
            w_pcWrite  = 1'b1;
            w_pcSource = 2'b10;
         end
         default: begin
            w_aluOp = 6'h00;
         end
      endcase
   end

   // Outputs are masked by reset so nothing strobes while i_rst_n is low.
   assign o_pcWrite       = i_rst_n & w_pcWrite;
   assign o_pcWriteCond   = i_rst_n & w_pcWriteCond;
   assign o_pcWriteCondNe = i_rst_n & w_pcWriteCondNe;
   assign o_iorD          = i_rst_n & w_iorD;
   assign o_memRead       = i_rst_n & w_memRead;
   assign o_memWrite      = i_rst_n & w_memWrite;
   assign o_irWrite       = i_rst_n & w_irWrite;
   assign o_regDst        = i_rst_n & w_regDst;
   assign o_regWrite      = i_rst_n & w_regWrite;
   assign o_memToReg      = i_rst_n & w_memToReg;
   assign o_extOp         = i_rst_n & w_extOp;
   assign o_aluSrcA       = i_rst_n & w_aluSrcA;
   assign o_aluSrcB       = i_rst_n ? w_aluSrcB : 2'b00;
   assign o_pcSource      = i_rst_n ? w_pcSource : 2'b00;
   assign o_aluOp         = i_rst_n ? ALUOP_W'(w_aluOp) : '0;
   assign o_illegal       = i_rst_n & w_illegal;
   assign o_state         = r_state;
   assign o_retired       = r_retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: instruction-level reference model
// with randomized opcodes, memory wait states and don't-care inputs.
module tb_multicycle_control;

   logic       i_clk;
   logic       i_rst_n;
   logic [5:0] i_instrCode;
   logic       i_memReady;
   logic       o_pcWrite, o_pcWriteCond, o_pcWriteCondNe, o_iorD, o_memRead, o_memWrite;
   logic       o_irWrite, o_regDst, o_regWrite, o_memToReg, o_extOp, o_aluSrcA;
   logic [1:0] o_aluSrcB, o_pcSource;
   logic [5:0] o_aluOp;
   logic       o_illegal;
   logic [3:0] o_state;
   logic [3:0] o_retired;

   int         checks;
   int         failures;
   int         model_ret;

   multicycle_control #(.MEM_HANDSHAKE(1), .ALUOP_W(6), .CNT_W(4)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_instrCode(i_instrCode), .i_memReady(i_memReady),
      .o_pcWrite(o_pcWrite), .o_pcWriteCond(o_pcWriteCond), .o_pcWriteCondNe(o_pcWriteCondNe),
      .o_iorD(o_iorD), .o_memRead(o_memRead), .o_memWrite(o_memWrite), .o_irWrite(o_irWrite),
      .o_regDst(o_regDst), .o_regWrite(o_regWrite), .o_memToReg(o_memToReg), .o_extOp(o_extOp),
      .o_aluSrcA(o_aluSrcA), .o_aluSrcB(o_aluSrcB), .o_pcSource(o_pcSource), .o_aluOp(o_aluOp),
      .o_illegal(o_illegal), .o_state(o_state), .o_retired(o_retired)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   wire [22:0] w_act = {o_pcWrite, o_pcWriteCond, o_pcWriteCondNe, o_iorD, o_memRead,
                        o_memWrite, o_irWrite, o_regDst, o_regWrite, o_memToReg, o_extOp,
                        o_aluSrcA, o_aluSrcB, o_pcSource, o_aluOp, o_illegal};

   function automatic bit is_legal(input logic [5:0] op);
      return op inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0D, 6'h0F, 6'h23, 6'h2B};
   endfunction

   // Expected control word for one cycle, straight from the per-state output table.
   function automatic logic [22:0] exp_ctrl(input int st, input logic [5:0] op,
                                            input logic rdy, input logic [5:0] code);
      logic pcw = 0, pcc = 0, pcn = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, rdst = 0;
      logic rwr = 0, m2r = 0, ext = 0, srca = 0, ill = 0;
      logic [1:0] srcb = 0, pcs = 0;
      logic [5:0] alu = 0;
      case (st)
         0:  begin mrd = 1; srcb = 2'b01; alu = 6'h09; irw = rdy; pcw = rdy; end
         1:  begin srcb = 2'b11; alu = 6'h09; ill = !is_legal(code); end
         2:  begin srca = 1; srcb = 2'b10; ext = 1; alu = 6'h09; end
         3:  begin mrd = 1; iord = 1; end
         4:  begin rwr = 1; m2r = 1; end
         5:  begin mwr = 1; iord = 1; end
         6:  begin srca = 1; alu = op; end
         7:  begin rdst = 1; rwr = 1; end
         8:  begin srca = 1; srcb = 2'b10; alu = op; ext = (op == 6'h08 || op == 6'h09); end
         9:  begin rwr = 1; end
         10: begin srca = 1; alu = op; pcs = 2'b01; pcc = (op == 6'h04); pcn = (op == 6'h05); end
         11: begin pcw = 1; pcs = 2'b10; end
         default: ;
      endcase
      return {pcw, pcc, pcn, iord, mrd, mwr, irw, rdst, rwr, m2r, ext, srca, srcb, pcs, alu, ill};
   endfunction

   // Entered at posedge+1; drives inputs, checks at negedge, returns at next posedge+1.
   task automatic run_cycle(input int st, input logic rdy, input logic [5:0] code,
                            input logic [5:0] op);
      logic [22:0] exp;
      i_memReady  = rdy;
      i_instrCode = code;
      exp = exp_ctrl(st, op, rdy, code);
      @(negedge i_clk);
      checks++;
      if (o_state !== 4'(st)) begin
         failures++;
         $display("FAIL state op=%h got=%0d exp=%0d", op, o_state, st);
      end
      checks++;
      if (w_act !== exp) begin
         failures++;
         $display("FAIL ctrl st=%0d op=%h got=%h exp=%h", st, op, w_act, exp);
      end
      checks++;
      if (o_retired !== 4'(model_ret)) begin
         failures++;
         $display("FAIL retired st=%0d got=%0d exp=%0d", st, o_retired, model_ret);
      end
      @(posedge i_clk);
      #1;
   endtask

   function automatic logic [5:0] junk();
      return 6'($urandom);
   endfunction

   task automatic mem_state(input int st, input int waits, input logic [5:0] op);
      for (int i = 0; i < waits; i++) run_cycle(st, 1'b0, junk(), op);
      run_cycle(st, 1'b1, junk(), op);
   endtask

   // Runs one whole instruction: state path derived from its opcode class.
   task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
      int ncyc;
      mem_state(0, fw, op);
      run_cycle(1, 1'($urandom), op, op);
      ncyc = 2 + fw;
      if (op == 6'h23) begin
         run_cycle(2, 1'($urandom), junk(), op);
         mem_state(3, mw, op);
         run_cycle(4, 1'($urandom), junk(), op);
         ncyc += 3 + mw;
      end else if (op == 6'h2B) begin
         run_cycle(2, 1'($urandom), junk(), op);
         mem_state(5, mw, op);
         ncyc += 2 + mw;
      end else if (op == 6'h00) begin
         run_cycle(6, 1'($urandom), junk(), op);
         run_cycle(7, 1'($urandom), junk(), op);
         ncyc += 2;
      end else if (op inside {6'h08, 6'h09, 6'h0D, 6'h0F}) begin
         run_cycle(8, 1'($urandom), junk(), op);
         run_cycle(9, 1'($urandom), junk(), op);
         ncyc += 2;
      end else if (op inside {6'h04, 6'h05}) begin
         run_cycle(10, 1'($urandom), junk(), op);
         ncyc += 1;
      end else if (op == 6'h02) begin
         run_cycle(11, 1'($urandom), junk(), op);
         ncyc += 1;
      end
      if (is_legal(op)) model_ret = (model_ret + 1) % 16;
      $display("instr op=%h fetch_wait=%0d mem_wait=%0d cycles=%0d retired=%0d",
               op, fw, mw, ncyc, model_ret);
   endtask

   task automatic do_reset();
      i_rst_n = 1'b0;
      i_memReady = 1'b1;
      #1;
      checks++;
      if (w_act !== 23'd0 || o_state !== 4'd0 || o_retired !== 4'd0) begin
         failures++;
         $display("FAIL reset_hold ctrl=%h state=%0d ret=%0d exp 0/0/0", w_act, o_state, o_retired);
      end
      model_ret = 0;
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0;
      i_memReady = 1'b1;
      i_instrCode = 6'h23;
      repeat (2) @(posedge i_clk);
      #1;
      do_reset();
   endtask

   task automatic test_fetch_wait();
      run_instr(6'h02, 3, 0);
   endtask

   task automatic test_load();
      run_instr(6'h23, 0, 0);
      run_instr(6'h23, 1, 2);
   endtask

   task automatic test_branch_imm();
      run_instr(6'h05, 0, 0);
      run_instr(6'h04, 0, 0);
      run_instr(6'h0D, 0, 0);
      run_instr(6'h08, 0, 0);
      run_instr(6'h00, 0, 0);
      run_instr(6'h2B, 0, 1);
   endtask

   task automatic test_illegal();
      run_instr(6'h3F, 0, 0);
      run_instr(6'h02, 0, 0);
   endtask

   task automatic test_async_reset_memwr();
      run_cycle(0, 1'b1, junk(), 6'h2B);
      run_cycle(1, 1'b0, 6'h2B, 6'h2B);
      run_cycle(2, 1'b0, junk(), 6'h2B);
      run_cycle(5, 1'b0, junk(), 6'h2B);
      i_memReady = 1'b0;
      #1;
      checks++;
      if (o_memWrite !== 1'b1 || o_state !== 4'd5) begin
         failures++;
         $display("FAIL memwr_wait memWrite=%b state=%0d exp 1/5", o_memWrite, o_state);
      end
      i_rst_n = 1'b0;
      #1;
      checks++;
      if (o_memWrite !== 1'b0 || o_state !== 4'd0 || o_retired !== 4'd0 || w_act !== 23'd0) begin
         failures++;
         $display("FAIL async_reset memWrite=%b state=%0d ret=%0d ctrl=%h exp all 0",
                  o_memWrite, o_state, o_retired, w_act);
      end
      model_ret = 0;
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      run_instr(6'h00, 0, 0);
   endtask

   task automatic test_random();
      logic [5:0] ops [10] = '{6'h00, 6'h08, 6'h09, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
      logic [5:0] op;
      int k;
      for (int n = 0; n < 150; n++) begin
         k = $urandom_range(0, 11);
         op = (k < 10) ? ops[k] : junk();
         run_instr(op, $urandom_range(0, 2), $urandom_range(0, 2));
      end
   endtask

   task automatic test_wrap();
      do_reset();
      for (int n = 0; n < 15; n++) run_instr(6'h02, 0, 0);
      checks++;
      if (o_retired !== 4'd15) begin
         failures++;
         $display("FAIL wrap_pre got=%0d exp=15", o_retired);
      end
      run_instr(6'h02, 0, 0);
      checks++;
      if (o_retired !== 4'd0) begin
         failures++;
         $display("FAIL wrap_post got=%0d exp=0", o_retired);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      model_ret = 0;
      test_reset();
      test_fetch_wait();
      test_load();
      test_branch_imm();
      test_illegal();
      test_async_reset_memwr();
      test_random();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter MEM_HANDSHAKE, default 1, meaning 1 = memory states wait on i_memReady, 0 = memory states last exactly one cycle.
REQ-002 Parameter ALUOP_W, default 6, meaning width of o_aluOp (min 6); the 6-bit opcode code is zero-extended into it.
REQ-003 Parameter CNT_W, default 16, meaning width of o_retired.
REQ-004 i_clk  in  1  single clock; all state updates on rising edge.
REQ-005 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 i_instrCode  in  6  opcode field from external instruction register, valid from DECODE onward.
REQ-007 i_memReady  in  1  memory completes the current access this cycle.
REQ-008 o_pcWrite, o_pcWriteCond, o_pcWriteCondNe  out  1 each  unconditional / BEQ-qualified / BNE-qualified PC write.
REQ-009 o_iorD, o_memRead, o_memWrite, o_irWrite  out  1 each  address select (1 = ALU result), memory strobes, IR load.
REQ-010 o_regDst, o_regWrite, o_memToReg, o_extOp, o_aluSrcA  out  1 each  as in single-cycle datapath; aluSrcA 0 = PC, 1 = rs.
REQ-011 o_aluSrcB  out  2  00 rt, 01 constant 4, 10 extended immediate, 11 sign-extended immediate << 2.
REQ-012 o_pcSource  out  2  00 ALU result, 01 ALU-out register, 10 jump target.
REQ-013 o_aluOp  out  ALUOP_W  ALU operation code (opcode encoding).
REQ-014 o_illegal  out  1  one-cycle pulse on undefined opcode.
REQ-015 o_state  out  4  current state encoding; o_retired  out  CNT_W  retired-instruction count.

Function
REQ-016 States/encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, IMMEXEC 8, IMMWB 9, BRANCH 10, JUMP 11; codes 12-15 -> FETCH next cycle, all outputs 0.
REQ-017 Outputs are Moore decoded from registered state and latched opcode; any output not listed for a state is 0.
REQ-018 FETCH: memRead=1, aluSrcB=01, aluOp=0x09; irWrite=pcWrite=1 only in the completing cycle (i_memReady=1, or always when MEM_HANDSHAKE=0); then DECODE.
REQ-019 DECODE: aluSrcB=11, aluOp=0x09; latch i_instrCode; next by opcode: 0x00 EXEC, 0x08/0x09/0x0D/0x0F IMMEXEC, 0x23/0x2B MEMADR, 0x04/0x05 BRANCH, 0x02 JUMP, other -> o_illegal=1, next FETCH.
REQ-020 MEMADR: aluSrcA=1, aluSrcB=10, extOp=1, aluOp=0x09; next MEMRD for 0x23, MEMWR for 0x2B.
REQ-021 MEMRD: memRead=1, iorD=1; hold until completion, then MEMWB. MEMWB: regWrite=1, memToReg=1; then FETCH.
REQ-022 MEMWR: memWrite=1, iorD=1; hold until completion, then FETCH.
REQ-023 EXEC: aluSrcA=1, aluSrcB=00, aluOp=latched opcode; then RWB. RWB: regDst=1, regWrite=1; then FETCH.
REQ-024 IMMEXEC: aluSrcA=1, aluSrcB=10, aluOp=latched opcode, extOp=1 for 0x08/0x09, 0 for 0x0D/0x0F; then IMMWB. IMMWB: regWrite=1; then FETCH.
REQ-025 BRANCH: aluSrcA=1, aluSrcB=00, aluOp=latched opcode, pcSource=01, pcWriteCond=1 for 0x04, pcWriteCondNe=1 for 0x05; then FETCH.
REQ-026 JUMP: pcWrite=1, pcSource=10; then FETCH.
REQ-027 Cycles per instruction with zero-wait memory: load 5, store 4, R-type 4, immediate 4, branch 3, jump 3, illegal 2.
REQ-028 o_retired increments by 1 on the final cycle of MEMWB, completing MEMWR, RWB, IMMWB, BRANCH, JUMP; wraps from all-ones to 0; illegal opcodes not counted.
REQ-029 i_memReady ignored outside FETCH, MEMRD, MEMWR; i_instrCode ignored outside DECODE.
REQ-030 Changes of i_instrCode after DECODE do not alter o_aluOp, o_extOp or branch selection.

Reset
REQ-031 While i_rst_n=0, immediately and regardless of clock: state FETCH, latched opcode 0, o_retired 0, every control output and o_illegal forced 0, o_state 0.
REQ-032 Reset asserted mid-instruction (including mid memory wait) abandons it with no further strobes; first rising edge after release starts a normal FETCH.

Verification
REQ-033 Reset release, MEM_HANDSHAKE=1, i_memReady=0 for 3 cycles then 1 -> o_memRead=1 four cycles, o_irWrite/o_pcWrite=1 only in cycle 4, o_state 0->1.
REQ-034 Opcode 0x23, zero-wait -> states 0,1,2,3,4,0; o_memToReg=o_regWrite=1 only in state 4; o_retired 0->1.
REQ-035 Opcode 0x05 -> state 10 with o_pcWriteCondNe=1, o_pcSource=01, o_aluOp=0x05; opcode 0x0D -> o_extOp=0 in state 8.
REQ-036 Opcode 0x3F -> o_illegal=1 for one cycle in DECODE, next state 0, o_retired unchanged.
REQ-037 i_rst_n low asynchronously during MEMWR wait -> o_memWrite drops to 0 before next edge, o_state=0, o_retired=0.
REQ-038 CNT_W=4, 16 jumps -> o_retired wraps 15->0.
